// File: rtl/conv_window_3x3_pkg.sv
// Shared constants, FSM encoding and configuration check for the
// 3x3 window assembler. FEATURE_WIDTH defaults to 8 when not set globally.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package conv_window_3x3_pkg;

    localparam int KERNEL  = 3;
    localparam int MIN_DIM = 3;
    localparam int FW      = `FEATURE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Frame must hold at least one window and a row must fit the delay RAM.
    function automatic logic cfg_ok(input int w, input int h, input int addr_w);
        return (w >= MIN_DIM) && (h >= MIN_DIM) && (w <= (1 << addr_w) - 1);
    endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Bundle between feature DMA / MAC array and the window assembler.
// master: drives config and stream; slave: returns windows and status.
interface conv_window_3x3_if #(
    parameter int FEATURE_WIDTH = conv_window_3x3_pkg::FW
);
    logic                         start;
    logic [9:0]                   row_size;
    logic [9:0]                   col_size;
    logic                         in_valid;
    logic [2*FEATURE_WIDTH-1:0]   in_data;
    logic                         out_valid;
    logic [18*FEATURE_WIDTH-1:0]  window_data;
    logic                         busy;
    logic                         frame_done;
    logic                         cfg_err;

    modport master (
        output start, row_size, col_size, in_valid, in_data,
        input  out_valid, window_data, busy, frame_done, cfg_err
    );

    modport slave (
        input  start, row_size, col_size, in_valid, in_data,
        output out_valid, window_data, busy, frame_done, cfg_err
    );
endinterface

// File: rtl/conv_row_delay.sv
// One-row delay line: SDP RAM + write/read pointers + bypass register.
// Ports: i_clr (reload pointers, i_w = row length), i_wr/i_data in, o_data out.
module conv_row_delay
    import conv_window_3x3_pkg::*;
#(
    parameter int DW     = 16,
    parameter int ADDR_W = 10
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_w,
    input  logic              i_wr,
    input  logic [DW-1:0]     i_data,
    output logic [DW-1:0]     o_data
);
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DW-1:0]     w_q;
    logic [DW-1:0]     r_byp;
    logic              r_q_fresh;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_raddr <= '0;
        end else if (i_clr) begin
            r_waddr <= '0;
            r_raddr <= '0 - i_w;
        end else if (i_wr) begin
            r_waddr <= r_waddr + ADDR_W'(1);
            r_raddr <= r_raddr + ADDR_W'(1);
        end
    end

    // Read one ahead so the next write finds its delayed word ready.
    assign w_rd_addr = r_raddr + ADDR_W'(1);

`ifdef device
    vendor_sdpram #(
        .DW (DW),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (system_clk),
        .we    (i_wr),
        .waddr (r_waddr),
        .wdata (i_data),
        .re    (i_wr),
        .raddr (w_rd_addr),
        .rdata (w_q)
    );
`else
    logic [DW-1:0] r_mem [2**ADDR_W];
    logic [DW-1:0] r_ram_q;

    always_ff @(posedge system_clk) begin
        if (i_wr) begin
            r_mem[r_waddr] <= i_data;
            r_ram_q        <= r_mem[w_rd_addr];
        end
    end

    assign w_q = r_ram_q;
`endif

    // After an idle cycle the RAM port is not trusted; serve the held word.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_fresh <= 1'b0;
            r_byp     <= '0;
        end else begin
            r_q_fresh <= i_wr;
            if (r_q_fresh)
                r_byp <= w_q;
        end
    end

    assign o_data = r_q_fresh ? w_q : r_byp;

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 sliding-window assembler (stride 1, no padding).
// Ports: system_clk, rst_n, bus (slave: config, stream in, windows/status out).
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int FEATURE_WIDTH = FW,
    parameter int ADDR_W        = 10
) (
    input  logic              system_clk,
    input  logic              rst_n,
    conv_window_3x3_if.slave  bus
);
    localparam int DW = 2 * FEATURE_WIDTH;
    localparam int NW = KERNEL * KERNEL;

    state_t r_state;
    state_t w_next;

    logic [9:0]    r_w, r_h, r_col, r_row;
    logic          w_cfg_ok, w_start_ok, w_start_bad;
    logic          w_acc, w_last_col, w_last, w_emit;
    logic [DW-1:0] w_a, w_b;
    logic [DW-1:0] w_col_in [KERNEL];
    // Columns c-2 and c-1 per row; column c is the live input.
    logic [DW-1:0] r_win [KERNEL][KERNEL-1];
    logic [NW*DW-1:0] w_win, r_window;
    logic          r_out_valid, r_frame_done, r_cfg_err;

    assign w_cfg_ok    = cfg_ok(int'(bus.row_size), int'(bus.col_size), ADDR_W);
    assign w_start_ok  = (r_state == ST_IDLE) && bus.start && w_cfg_ok;
    assign w_start_bad = (r_state == ST_IDLE) && bus.start && !w_cfg_ok;
    assign w_acc       = (r_state == ST_RUN) && bus.in_valid;
    assign w_last_col  = (r_col == r_w - 10'd1);
    assign w_last      = w_acc && w_last_col && (r_row == r_h - 10'd1);
    assign w_emit      = w_acc && (r_row >= 10'd2) && (r_col >= 10'd2);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start_ok) w_next = ST_RUN;
            ST_RUN:  if (w_last)     w_next = ST_DONE;
            ST_DONE:                 w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w   <= '0;
            r_h   <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_ok) begin
            r_w   <= bus.row_size;
            r_h   <= bus.col_size;
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 10'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    conv_row_delay #(
        .DW     (DW),
        .ADDR_W (ADDR_W)
    ) u_dly_a (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .i_clr      (w_start_ok),
        .i_w        (ADDR_W'(bus.row_size)),
        .i_wr       (w_acc),
        .i_data     (bus.in_data),
        .o_data     (w_a)
    );

    conv_row_delay #(
        .DW     (DW),
        .ADDR_W (ADDR_W)
    ) u_dly_b (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .i_clr      (w_start_ok),
        .i_w        (ADDR_W'(bus.row_size)),
        .i_wr       (w_acc),
        .i_data     (w_a),
        .o_data     (w_b)
    );

    assign w_col_in[0] = w_b;
    assign w_col_in[1] = w_a;
    assign w_col_in[2] = bus.in_data;

    always_comb begin
        w_win = '0;
        for (int i = 0; i < KERNEL; i++) begin
            w_win[(KERNEL*i)*DW   +: DW] = r_win[i][0];
            w_win[(KERNEL*i+1)*DW +: DW] = r_win[i][1];
            w_win[(KERNEL*i+2)*DW +: DW] = w_col_in[i];
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '{default: '0};
        end else if (w_acc) begin
            for (int i = 0; i < KERNEL; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= w_col_in[i];
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (w_emit)
                r_window <= w_win;
            r_out_valid  <= w_emit;
            r_frame_done <= w_last;
            r_cfg_err    <= w_start_bad;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.window_data = r_window;
    assign bus.frame_done  = r_frame_done;
    assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3.
// Drives the interface, collects windows, checks with immediate assertions.
module tb_conv_window_3x3;
    import conv_window_3x3_pkg::*;

    localparam int DW    = 2 * FW;
    localparam int WIN_W = 9 * DW;

    logic system_clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    logic [WIN_W-1:0] win_q [$];
    bit               fd_q  [$];
    int               n_fd;
    int               n_cfg;

    conv_window_3x3_if #(.FEATURE_WIDTH(FW)) bus ();

    conv_window_3x3 #(
        .FEATURE_WIDTH (FW),
        .ADDR_W        (10)
    ) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    always @(negedge system_clk) begin
        if (bus.out_valid) begin
            win_q.push_back(bus.window_data);
            fd_q.push_back(bus.frame_done);
        end
        if (bus.frame_done) n_fd++;
        if (bus.cfg_err)    n_cfg++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs,
                       input logic [WIN_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge system_clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        bus.start    = 1'b1;
        bus.row_size = 10'(w);
        bus.col_size = 10'(h);
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic push(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    function automatic logic [WIN_W-1:0] wq(input int i);
        return (i < win_q.size()) ? win_q[i] : '1;
    endfunction

    function automatic logic fdq(input int i);
        return (i < fd_q.size()) ? fd_q[i] : 1'b0;
    endfunction

    // Window whose newest element is (r, c) in a frame of width w, data = idx + off.
    function automatic logic [WIN_W-1:0] mkwin(input int r, input int c,
                                                input int w, input int off);
        logic [WIN_W-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(3*i+j)*DW +: DW] = DW'((r - 2 + i) * w + (c - 2 + j) + off);
        return v;
    endfunction

    initial begin
        int b, f, e;
        int exp0 [9];
        logic [WIN_W-1:0] v;
        logic [DW-1:0] centre;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start    = 1'b0;
        bus.row_size = '0;
        bus.col_size = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge system_clk);
        #1;
        chk("rst_out_valid",  bus.out_valid,   0);
        chk("rst_window",     bus.window_data, 0);
        chk("rst_busy",       bus.busy,        0);
        chk("rst_frame_done", bus.frame_done,  0);
        chk("rst_cfg_err",    bus.cfg_err,     0);
        rst_n = 1'b1;
        cycle();

        // 4x4 continuous frame
        b = win_q.size(); f = n_fd;
        do_start(4, 4);
        chk("t1_busy_high", bus.busy, 1);
        for (int i = 0; i < 16; i++) push(i);
        gap(3);
        chk("t1_busy_low", bus.busy, 0);
        chk("t1_nwin", win_q.size() - b, 4);
        exp0 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        v = '0;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(exp0[k]);
        chk("t1_win0", wq(b), v);
        chk("t1_win1", wq(b+1), mkwin(2, 3, 4, 0));
        chk("t1_win2", wq(b+2), mkwin(3, 2, 4, 0));
        chk("t1_win3", wq(b+3), mkwin(3, 3, 4, 0));
        chk("t1_fd_on_last", fdq(b+3), 1);
        chk("t1_fd_count", n_fd - f, 1);

        // 5x3 with toggling valid and a 3-cycle gap at each row wrap
        b = win_q.size();
        do_start(5, 3);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) begin
                push(r * 5 + c);
                gap(1);
                if (c == 4) gap(3);
            end
        gap(2);
        chk("t2_nwin", win_q.size() - b, 3);
        for (int c = 2; c < 5; c++)
            chk("t2_win", wq(b + c - 2), mkwin(2, c, 5, 0));

        // rejected configuration
        b = win_q.size(); e = n_cfg;
        do_start(2, 8);
        chk("t3_cfg_err_pulse", bus.cfg_err, 1);
        chk("t3_busy", bus.busy, 0);
        cycle();
        chk("t3_cfg_err_clear", bus.cfg_err, 0);
        for (int i = 0; i < 16; i++) push(i);
        gap(2);
        chk("t3_cfg_err_count", n_cfg - e, 1);
        chk("t3_no_windows", win_q.size() - b, 0);

        // start pulsed mid-frame is ignored
        b = win_q.size(); f = n_fd;
        do_start(4, 4);
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                bus.start    = 1'b1;
                bus.row_size = 10'd3;
                bus.col_size = 10'd3;
            end
            push(i + 40);
            bus.start = 1'b0;
        end
        gap(3);
        chk("t4_nwin", win_q.size() - b, 4);
        chk("t4_win0", wq(b),   mkwin(2, 2, 4, 40));
        chk("t4_win3", wq(b+3), mkwin(3, 3, 4, 40));
        chk("t4_fd_count", n_fd - f, 1);

        // reset mid-frame, then a fresh frame
        do_start(8, 8);
        for (int i = 0; i < 32; i++) push(i + 500);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", bus.out_valid,   0);
        chk("t5_rst_window",    bus.window_data, 0);
        chk("t5_rst_busy",      bus.busy,        0);
        cycle();
        rst_n = 1'b1;
        cycle();
        b = win_q.size();
        do_start(4, 4);
        for (int i = 0; i < 16; i++) push(i + 200);
        gap(3);
        chk("t5_nwin", win_q.size() - b, 4);
        for (int k = 0; k < 4; k++)
            chk("t5_win", wq(b + k), mkwin(2 + k / 2, 2 + k % 2, 4, 200));

        // widest legal row is accepted
        do_start(1023, 3);
        chk("t6_busy_w1023", bus.busy, 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // 1023x4 incrementing
        b = win_q.size(); f = n_fd;
        do_start(1023, 4);
        for (int i = 0; i < 1023 * 4; i++) push(i);
        gap(3);
        chk("t7_nwin", win_q.size() - b, 2042);
        v = wq(b + 2041);
        centre = v[4*DW +: DW];
        chk("t7_centre", centre, DW'(2 * 1023 + 1021));
        chk("t7_last_win", v, mkwin(3, 1022, 1023, 0));
        chk("t7_first_win", wq(b), mkwin(2, 2, 1023, 0));
        chk("t7_fd_on_last", fdq(b + 2041), 1);
        chk("t7_fd_count", n_fd - f, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_3x3.md
# conv_window_3x3

Streaming 3×3 sliding-window assembler for the convolution datapath. It accepts a raster-order feature stream, one packed 2-lane word per accepted element. It delays the stream by one and two rows through RAM-based row delays, then assembles the nine words of each fully-populated 3×3 neighbourhood (stride 1, no padding). The window is presented to the MAC array as one wide word. It sits between the feature-map read DMA and the convolution MAC stage.

## Interface
- FEATURE_WIDTH, `FEATURE_WIDTH: width of one feature lane; one element word is 2*FEATURE_WIDTH.
- ADDR_W, 10: row-delay RAM address width; the RAM depth is 2**ADDR_W.
- system_clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that latches the configuration and arms a frame.
- row_size  in  10  frame width W, in elements; sampled on start.
- col_size  in  10  frame height H, in rows; sampled on start.
- in_valid  in  1  an element is present on in_data this cycle. There is no ready signal; the block always accepts while in RUN.
- in_data  in  2*FEATURE_WIDTH  element word.
- out_valid  out  1  window_data holds a new window.
- window_data  out  18*FEATURE_WIDTH  nine words. Word k = 3*i + j sits at bits [k*2F +: 2F]. i = 0 is row r-2 (oldest) and i = 2 is the current row. j = 0 is column c-2 and j = 2 is column c.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start with W≥3, H≥3 and W≤2**ADDR_W−1: latch W and H, clear the column and row counters, go to RUN.
  - On start with any other configuration: pulse cfg_err and stay in IDLE.
  - in_valid is ignored in IDLE.
- RUN, on each in_valid:
  - Write in_data into row delay A. A's output, the element written W writes earlier, goes into row delay B.
  - Shift the three column registers per row: row 2 takes in_data, row 1 takes A's output, row 0 takes B's output.
  - Advance col_cnt. It wraps from W−1 to 0 and then increments row_cnt.
- A window is emitted when an element at (row_cnt ≥ 2, col_cnt ≥ 2) is accepted. Each frame emits (H−2)*(W−2) windows.
- Row delays:
  - Write address increments mod 2**ADDR_W on each write.
  - Read address = write address − W, mod 2**ADDR_W, registered in the same way as the write address.
  - A one-entry bypass register holds the last read word. When a write follows an idle cycle, the output comes from this register, so an idle gap never corrupts alignment.
- start in RUN or DONE is ignored. in_valid in DONE is ignored.
- Accepting the element at (H−1, W−1) moves the FSM to DONE. DONE lasts one cycle and then returns to IDLE.
- Reset:
  - Asynchronous; all state and outputs clear immediately.
  - Row-delay RAM contents are not cleared. Stale contents never reach the output, because windows are gated by the row and column counters.

## Timing
- Reset values: out_valid 0, window_data 0, busy 0, frame_done 0, cfg_err 0, FSM in IDLE.
- Latency: out_valid and window_data are registered one cycle after the qualifying in_valid. window_data holds its value between windows.
- Throughput: one element per cycle. in_valid may have arbitrary gaps, including a gap at a row wrap.
- busy goes high the cycle after start and low the cycle after DONE.
- frame_done is asserted in the same cycle as the final out_valid.
- cfg_err is asserted the cycle after the rejected start.
- A new start is accepted the cycle after frame_done.

## Structure
- Shared package holds:
  - KERNEL = 3.
  - FSM state encodings, 2 bits: IDLE = 0, RUN = 1, DONE = 2.
  - MIN_DIM = 3.
- FEATURE_WIDTH comes from the global parameters include.
- One sub-module, conv_row_delay. It wraps the dual-port RAM (vendor RAM or simulation SDPRAM, selected by `device`) with the address logic and the bypass register. It is instantiated twice: A and B.
- Top level: FSM, counters, 3×3 register array, output register.

## Test plan
- W=4, H=4, in_data = r*4+c, continuous stream:
  - Exactly 4 windows.
  - The first window's words k=0..8 are 0,1,2,4,5,6,8,9,10.
  - frame_done coincides with the window centred on 10.
- W=5, H=3 with in_valid toggling 1/0, plus a 3-cycle gap at the row wrap: 3 windows, identical to the gap-free run.
- Configuration rejection:
  - start with W=2, H=8: cfg_err pulses once, busy stays 0, no out_valid.
  - start with W=1023, H=3: accepted.
- start pulsed mid-frame is ignored: the window count and data are unchanged.
- rst_n asserted mid-frame (after row 3 of an 8×8 frame):
  - Outputs go to 0 immediately.
  - A fresh 4×4 frame afterwards produces the correct 4 windows with no stale data.
- W=1023, H=4, incrementing data: 2042 windows. The centre word of the last window = 2*1023+1021 (mod 2^(2F)).
